instr_sequencer: RTL and testbench

Instruction fetch/sequencing unit: the front end that drives the ALU's opcode/argument inputs and consumes its jump outputs.
- Owns the program counter and addresses a synchronous program ROM (1-cycle read latency).
- Presents each fetched instruction to the ALU in the same cycle it arrives, so clock cycle = instruction cycle.
- Applies ALU jump requests with zero bubble, and handles memory stalls, halt and restart.

---
 rtl/instr_sequencer_pkg.sv | 27 ++
 rtl/instr_sequencer_pc_next_mux.sv | 26 ++
 rtl/instr_sequencer.sv | 146 ++++++++++++++
 tb/tb_instr_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared opcode header for the ALU and the instruction sequencer.
// NOP and HLT sit outside the ALU's opcode set; the ALU's default case holds acc for both.
package instr_sequencer_pkg;

    localparam int OPCODE_WIDTH = 4;
    localparam int ARG_WIDTH    = 8;
    localparam int INSTR_WIDTH  = OPCODE_WIDTH + ARG_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] OP_LD  = 4'h0;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'h2;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'h3;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 4'h8;
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = 4'h9;
    localparam logic [OPCODE_WIDTH-1:0] OP_NOP = 4'hE;
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 4'hF;

    // True for opcodes the ALU actually executes.
    function automatic logic is_alu_op(input logic [OPCODE_WIDTH-1:0] op);
        return (op != OP_NOP) && (op != OP_HLT);
    endfunction

    // True for opcodes that update the carry flag.
    function automatic logic is_carry_op(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/instr_sequencer_pc_next_mux.sv
// Next ROM address select: hold (stall or halt), jump target, or pc+1 wrapping to 0.
module instr_sequencer_pc_next_mux
    import instr_sequencer_pkg::*;
(
    input  logic                 i_hold,
    input  logic                 i_jmp,
    input  logic [ARG_WIDTH-1:0] i_jmp_addr,
    input  logic [ARG_WIDTH-1:0] i_pc,
    output logic [ARG_WIDTH-1:0] o_next
);

    logic [ARG_WIDTH-1:0] w_pc_inc;

    assign w_pc_inc = i_pc + ARG_WIDTH'(1);

    // Hold outranks jump, jump outranks increment.
    always_comb begin
        o_next = w_pc_inc;
        if (i_hold) begin
            o_next = i_pc;
        end else if (i_jmp) begin
            o_next = i_jmp_addr;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction fetch/sequencing front end for the ALU.
// Drives a synchronous program ROM (1-cycle latency) and issues each fetched word to the
// ALU in the cycle it arrives; ALU jumps redirect the ROM address in the same cycle.
// Optional macro INSTR_COUNT_EN adds a saturating retired-instruction counter (instr_count).
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter logic [ARG_WIDTH-1:0] RESET_ADDR = '0,
    parameter int                   CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    output logic [ARG_WIDTH-1:0]   mem_addr,
    output logic                   mem_en,
    input  logic [INSTR_WIDTH-1:0] instr_data,
    input  logic                   mem_ready,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [ARG_WIDTH-1:0]   argument,
    output logic                   alu_ce,
    output logic                   cy_ce,
    input  logic                   jmp_ce,
    input  logic [ARG_WIDTH-1:0]   jmp_addr,
    output logic [ARG_WIDTH-1:0]   pc,
    output logic                   halted,
`ifdef INSTR_COUNT_EN
    output logic [CNT_WIDTH-1:0]   instr_count,
`endif
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [ARG_WIDTH-1:0]    r_pc;
    logic                    r_halted;

    logic [OPCODE_WIDTH-1:0] w_rom_op;
    logic [ARG_WIDTH-1:0]    w_rom_arg;
    logic                    w_valid;
    logic                    w_is_hlt;
    logic                    w_issue;
    logic [ARG_WIDTH-1:0]    w_next_addr;

    if (CNT_WIDTH < 1) begin : g_cnt_width_check
        $error("CNT_WIDTH must be at least 1");
    end

    assign w_rom_op  = instr_data[INSTR_WIDTH-1:ARG_WIDTH];
    assign w_rom_arg = instr_data[ARG_WIDTH-1:0];
    assign w_valid   = (r_state == S_EXEC) && mem_ready;
    assign w_is_hlt  = w_valid && (w_rom_op == OP_HLT);
    // An instruction is issued only when valid data arrives and it is not HLT.
    assign w_issue   = w_valid && !w_is_hlt;

    instr_sequencer_pc_next_mux u_pc_next_mux (
        .i_hold     (!w_issue),
        .i_jmp      (jmp_ce),
        .i_jmp_addr (jmp_addr),
        .i_pc       (r_pc),
        .o_next     (w_next_addr)
    );

    // ROM address and enable; kept apart from the issue logic so the ALU jump path stays acyclic.
    assign mem_addr = (r_state == S_EXEC) ? w_next_addr :
                      (r_state == S_HALT) ? r_pc : RESET_ADDR;
    assign mem_en   = (r_state == S_FETCH) || (r_state == S_EXEC);

    // Issue the ROM word to the ALU, or a NOP when nothing valid is executing.
    always_comb begin
        opcode   = OP_NOP;
        argument = '0;
        alu_ce   = 1'b0;
        cy_ce    = 1'b0;
        if (w_issue) begin
            opcode   = w_rom_op;
            argument = w_rom_arg;
            alu_ce   = is_alu_op(w_rom_op);
            cy_ce    = is_carry_op(w_rom_op);
        end
    end

    // Sequencer state, program counter and halted flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_ADDR;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_pc    <= RESET_ADDR;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_pc <= w_next_addr;
                    if (w_is_hlt) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (run) begin
                        r_state  <= S_FETCH;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pc     = r_pc;
    assign halted = r_halted;
    assign busy   = (r_state == S_FETCH) || (r_state == S_EXEC);

`ifdef INSTR_COUNT_EN
    logic [CNT_WIDTH-1:0] r_instr_count;

    // Count retired instructions, saturating at all-ones; restart from zero on every run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= '0;
        end else if (r_state == S_FETCH) begin
            r_instr_count <= '0;
        end else if (w_issue && (r_instr_count != {CNT_WIDTH{1'b1}})) begin
            r_instr_count <= r_instr_count + CNT_WIDTH'(1);
        end
    end

    assign instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a synchronous ROM model and a tiny ALU jump model.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    run;
    logic [ARG_WIDTH-1:0]    mem_addr;
    logic                    mem_en;
    logic [INSTR_WIDTH-1:0]  instr_data;
    logic                    mem_ready;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [ARG_WIDTH-1:0]    argument;
    logic                    alu_ce;
    logic                    cy_ce;
    logic                    jmp_ce;
    logic [ARG_WIDTH-1:0]    jmp_addr;
    logic [ARG_WIDTH-1:0]    pc;
    logic                    halted;
    logic                    busy;
`ifdef INSTR_COUNT_EN
    logic [15:0]             instr_count;
`endif

    logic [INSTR_WIDTH-1:0]  rom [256];
    logic [INSTR_WIDTH-1:0]  rom_q = '0;
    logic [7:0]              acc = 8'd5;

    int checks = 0;
    int passes = 0;

    instr_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .mem_addr   (mem_addr),
        .mem_en     (mem_en),
        .instr_data (instr_data),
        .mem_ready  (mem_ready),
        .opcode     (opcode),
        .argument   (argument),
        .alu_ce     (alu_ce),
        .cy_ce      (cy_ce),
        .jmp_ce     (jmp_ce),
        .jmp_addr   (jmp_addr),
        .pc         (pc),
        .halted     (halted),
`ifdef INSTR_COUNT_EN
        .instr_count(instr_count),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) rom_q <= rom[mem_addr];
    end
    assign instr_data = rom_q;

    // ALU jump outputs: JMP always, JZ when acc is zero; target is the argument.
    always_comb begin
        jmp_ce   = 1'b0;
        jmp_addr = argument;
        if (opcode == OP_JMP) jmp_ce = 1'b1;
        if (opcode == OP_JZ && acc == 8'd0) jmp_ce = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [INSTR_WIDTH-1:0] ins(input logic [OPCODE_WIDTH-1:0] op,
                                                   input logic [ARG_WIDTH-1:0] arg);
        return {op, arg};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = ins(OP_NOP, 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
    endtask

    task automatic start();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic test_reset();
        clear_rom();
        do_reset();
        checks++; if (opcode !== OP_NOP) $display("FAIL reset_opcode: got %0h expected %0h", opcode, OP_NOP); else passes++;
        checks++; if (argument !== 8'h00) $display("FAIL reset_argument: got %0h expected 0", argument); else passes++;
        checks++; if (mem_addr !== 8'h00) $display("FAIL reset_mem_addr: got %0h expected 0", mem_addr); else passes++;
        checks++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en: got %0b expected 0", mem_en); else passes++;
        checks++; if (busy !== 1'b0 || halted !== 1'b0) $display("FAIL reset_flags: got busy=%0b halted=%0b expected 0/0", busy, halted); else passes++;
        checks++; if (pc !== 8'h00) $display("FAIL reset_pc: got %0h expected 0", pc); else passes++;
`ifdef INSTR_COUNT_EN
        checks++; if (instr_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", instr_count); else passes++;
`endif
    endtask

    task automatic test_basic_halt();
        clear_rom();
        rom[0] = ins(OP_LD, 8'h01);
        rom[1] = ins(OP_ADD, 8'h02);
        rom[2] = ins(OP_HLT, 8'h00);
        do_reset();
        start();
        checks++; if (mem_en !== 1'b1 || mem_addr !== 8'h00 || opcode !== OP_NOP || busy !== 1'b1)
            $display("FAIL fetch_cycle: got en=%0b addr=%0h op=%0h busy=%0b expected 1/0/%0h/1", mem_en, mem_addr, opcode, busy, OP_NOP); else passes++;
        tick();
        checks++; if (opcode !== OP_LD || argument !== 8'h01 || alu_ce !== 1'b1 || cy_ce !== 1'b0)
            $display("FAIL issue_ld: got op=%0h arg=%0h alu_ce=%0b cy_ce=%0b expected %0h/1/1/0", opcode, argument, alu_ce, cy_ce, OP_LD); else passes++;
        checks++; if (mem_addr !== 8'h01 || pc !== 8'h00) $display("FAIL addr_ld: got addr=%0h pc=%0h expected 1/0", mem_addr, pc); else passes++;
        run = 1'b1;
        tick();
        run = 1'b0;
        checks++; if (opcode !== OP_ADD || argument !== 8'h02 || cy_ce !== 1'b1 || mem_addr !== 8'h02 || pc !== 8'h01)
            $display("FAIL issue_add: got op=%0h arg=%0h cy_ce=%0b addr=%0h pc=%0h expected %0h/2/1/2/1", opcode, argument, cy_ce, mem_addr, pc, OP_ADD); else passes++;
        tick();
        checks++; if (opcode !== OP_NOP || alu_ce !== 1'b0 || mem_addr !== 8'h02 || pc !== 8'h02 || halted !== 1'b0)
            $display("FAIL hlt_cycle: got op=%0h alu_ce=%0b addr=%0h pc=%0h halted=%0b expected %0h/0/2/2/0", opcode, alu_ce, mem_addr, pc, halted, OP_NOP); else passes++;
        tick();
        checks++; if (halted !== 1'b1 || busy !== 1'b0 || mem_en !== 1'b0 || pc !== 8'h02 || opcode !== OP_NOP)
            $display("FAIL halt_state: got halted=%0b busy=%0b en=%0b pc=%0h op=%0h expected 1/0/0/2/%0h", halted, busy, mem_en, pc, opcode, OP_NOP); else passes++;
`ifdef INSTR_COUNT_EN
        checks++; if (instr_count !== 16'd2) $display("FAIL count_after_run: got %0d expected 2", instr_count); else passes++;
`endif
        tick();
        checks++; if (halted !== 1'b1 || pc !== 8'h02) $display("FAIL halt_hold: got halted=%0b pc=%0h expected 1/2", halted, pc); else passes++;
        start();
        checks++; if (halted !== 1'b0 || busy !== 1'b1 || mem_addr !== 8'h00 || mem_en !== 1'b1)
            $display("FAIL restart_fetch: got halted=%0b busy=%0b addr=%0h en=%0b expected 0/1/0/1", halted, busy, mem_addr, mem_en); else passes++;
        tick();
        checks++; if (opcode !== OP_LD || pc !== 8'h00) $display("FAIL restart_exec: got op=%0h pc=%0h expected %0h/0", opcode, pc, OP_LD); else passes++;
`ifdef INSTR_COUNT_EN
        checks++; if (instr_count !== 16'd0) $display("FAIL count_cleared: got %0d expected 0", instr_count); else passes++;
`endif
    endtask

    task automatic test_jump();
        clear_rom();
        rom[3]    = ins(OP_JMP, 8'h10);
        rom[8'h10] = ins(OP_SUB, 8'h03);
        rom[8'h11] = ins(OP_HLT, 8'h00);
        do_reset();
        start();
        repeat (4) tick();
        checks++; if (opcode !== OP_JMP || pc !== 8'h03 || mem_addr !== 8'h10)
            $display("FAIL jmp_same_cycle: got op=%0h pc=%0h addr=%0h expected %0h/3/10", opcode, pc, mem_addr, OP_JMP); else passes++;
        tick();
        checks++; if (pc !== 8'h10 || opcode !== OP_SUB || argument !== 8'h03 || cy_ce !== 1'b1 || mem_addr !== 8'h11)
            $display("FAIL jmp_target: got pc=%0h op=%0h arg=%0h cy_ce=%0b addr=%0h expected 10/%0h/3/1/11", pc, opcode, argument, cy_ce, mem_addr, OP_SUB); else passes++;
    endtask

    task automatic test_cond_jump();
        clear_rom();
        rom[0]     = ins(OP_JZ, 8'h20);
        rom[1]     = ins(OP_HLT, 8'h00);
        rom[8'h20] = ins(OP_HLT, 8'h00);
        acc = 8'd5;
        do_reset();
        start();
        tick();
        checks++; if (opcode !== OP_JZ || mem_addr !== 8'h01) $display("FAIL jz_not_taken: got op=%0h addr=%0h expected %0h/1", opcode, mem_addr, OP_JZ); else passes++;
        acc = 8'd0;
        #1;
        checks++; if (mem_addr !== 8'h20) $display("FAIL jz_taken: got addr=%0h expected 20", mem_addr); else passes++;
        tick();
        checks++; if (pc !== 8'h20) $display("FAIL jz_taken_pc: got pc=%0h expected 20", pc); else passes++;
        acc = 8'd5;
    endtask

    task automatic test_stall();
        clear_rom();
        rom[0] = ins(OP_JMP, 8'h05);
        rom[5] = ins(OP_ADD, 8'h04);
        rom[6] = ins(OP_HLT, 8'h00);
        do_reset();
        start();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (opcode !== OP_NOP || argument !== 8'h00 || alu_ce !== 1'b0 || mem_addr !== 8'h05 || pc !== 8'h05)
                $display("FAIL stall_%0d: got op=%0h arg=%0h alu_ce=%0b addr=%0h pc=%0h expected %0h/0/0/5/5", k, opcode, argument, alu_ce, mem_addr, pc, OP_NOP); else passes++;
            if (k == 0) tick();
        end
        mem_ready = 1'b1;
        #1;
        checks++; if (opcode !== OP_ADD || argument !== 8'h04 || mem_addr !== 8'h06)
            $display("FAIL stall_release: got op=%0h arg=%0h addr=%0h expected %0h/4/6", opcode, argument, mem_addr, OP_ADD); else passes++;
        tick();
        checks++; if (pc !== 8'h06) $display("FAIL stall_next_pc: got pc=%0h expected 6", pc); else passes++;
    endtask

    task automatic test_wrap();
        clear_rom();
        rom[0]     = ins(OP_JMP, 8'hFF);
        rom[8'hFF] = ins(OP_LD, 8'h07);
        do_reset();
        start();
        tick();
        tick();
        checks++; if (pc !== 8'hFF || opcode !== OP_LD || mem_addr !== 8'h00)
            $display("FAIL wrap_addr: got pc=%0h op=%0h addr=%0h expected ff/%0h/0", pc, opcode, mem_addr, OP_LD); else passes++;
        tick();
        checks++; if (pc !== 8'h00 || opcode !== OP_JMP) $display("FAIL wrap_pc: got pc=%0h op=%0h expected 0/%0h", pc, opcode, OP_JMP); else passes++;
    endtask

    task automatic test_async_reset();
        clear_rom();
        rom[0] = ins(OP_LD, 8'h01);
        rom[1] = ins(OP_ADD, 8'h02);
        rom[2] = ins(OP_HLT, 8'h00);
        do_reset();
        start();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== 8'h00 || busy !== 1'b0 || mem_en !== 1'b0 || opcode !== OP_NOP || mem_addr !== 8'h00 || alu_ce !== 1'b0)
            $display("FAIL async_reset: got pc=%0h busy=%0b en=%0b op=%0h addr=%0h alu_ce=%0b expected 0/0/0/%0h/0/0", pc, busy, mem_en, opcode, mem_addr, alu_ce, OP_NOP); else passes++;
`ifdef INSTR_COUNT_EN
        checks++; if (instr_count !== 16'd0) $display("FAIL async_reset_count: got %0d expected 0", instr_count); else passes++;
`endif
        #1 rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || pc !== 8'h00) $display("FAIL post_reset_idle: got busy=%0b pc=%0h expected 0/0", busy, pc); else passes++;
        start();
        tick();
        checks++; if (opcode !== OP_LD || pc !== 8'h00 || mem_addr !== 8'h01)
            $display("FAIL post_reset_run: got op=%0h pc=%0h addr=%0h expected %0h/0/1", opcode, pc, mem_addr, OP_LD); else passes++;
    endtask

    initial begin
        rst_n = 1'b0;
        run = 1'b0;
        mem_ready = 1'b1;
        test_reset();
        test_basic_halt();
        test_jump();
        test_cond_jump();
        test_stall();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
